// File: rtl/note_pkg.sv
// Shared note codes, classification codes, 7-segment glyphs and FSM states
// for the note-word classifier.
package note_pkg;

   localparam logic [2:0] NOTE_TERM = 3'b000;
   localparam logic [2:0] NOTE_A    = 3'b001;
   localparam logic [2:0] NOTE_B    = 3'b010;
   localparam logic [2:0] NOTE_C    = 3'b011;
   localparam logic [2:0] NOTE_D    = 3'b100;
   localparam logic [2:0] NOTE_E    = 3'b101;
   localparam logic [2:0] NOTE_F    = 3'b110;
   localparam logic [2:0] NOTE_G    = 3'b111;

   localparam logic [1:0] TIPO_DO   = 2'b11;
   localparam logic [1:0] TIPO_RE   = 2'b10;
   localparam logic [1:0] TIPO_MI   = 2'b01;
   localparam logic [1:0] TIPO_NONE = 2'b00;

   // Glyphs are stored active-low, i.e. already inverted from {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_A    = ~7'h77;
   localparam logic [6:0] SEG_B    = ~7'h7C;
   localparam logic [6:0] SEG_C    = ~7'h39;
   localparam logic [6:0] SEG_D    = ~7'h5E;
   localparam logic [6:0] SEG_E    = ~7'h79;
   localparam logic [6:0] SEG_F    = ~7'h71;
   localparam logic [6:0] SEG_G    = ~7'h3D;
   localparam logic [6:0] SEG_DASH = ~7'h40;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, EMIT} state_t;

   function automatic logic [1:0] tipoOf(input logic [3:0] key);
      case (key)
         {1'b0, NOTE_C}: tipoOf = TIPO_DO;
         {1'b0, NOTE_D}: tipoOf = TIPO_RE;
         {1'b0, NOTE_E}: tipoOf = TIPO_MI;
         default:        tipoOf = TIPO_NONE;
      endcase
   endfunction

endpackage

// File: rtl/note_word_classifier_if.sv
// Note stream handshake between the keypad front end (master) and the
// classifier (slave).
interface note_word_classifier_if;
   logic       in_valid;
   logic       in_ready;
   logic       Tom;
   logic [2:0] Nota;

   modport master (output in_valid, Tom, Nota, input in_ready);
   modport slave  (input in_valid, Tom, Nota, output in_ready);
endinterface

// File: rtl/note_seg_decoder.sv
// Combinational note-to-glyph lookup; the terminator shows a dash.
module note_seg_decoder
   import note_pkg::*;
(
   input  logic [2:0] nota_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (nota_i)
         NOTE_A:  seg_o = SEG_A;
         NOTE_B:  seg_o = SEG_B;
         NOTE_C:  seg_o = SEG_C;
         NOTE_D:  seg_o = SEG_D;
         NOTE_E:  seg_o = SEG_E;
         NOTE_F:  seg_o = SEG_F;
         NOTE_G:  seg_o = SEG_G;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/note_word_classifier.sv
// Groups accepted notes into terminator-delimited words, echoes each note on a
// 7-segment display and classifies each word. Define WORD_HIST_EN for a
// readable buffer of the last emitted word.
module note_word_classifier
   import note_pkg::*;
#(
   parameter  int MAX_LEN        = 8,
   parameter  bit CLASS_BY_FIRST = 1'b0,
   localparam int LEN_W          = $clog2(MAX_LEN + 1)
)(
   input  logic                    clk,
   input  logic                    Reset,
   note_word_classifier_if.slave   noteBus,
   output logic [6:0]              Saida,
   output logic                    End,
   output logic [1:0]              Tipo,
   output logic [LEN_W-1:0]        Len,
   output logic                    Overflow
`ifdef WORD_HIST_EN
   ,
   input  logic [LEN_W-1:0]        hist_idx,
   output logic [3:0]              hist_note
`endif
);

   state_t           state_q;
   logic [LEN_W-1:0] count_q;
   logic [3:0]       key_q;
   logic [6:0]       saida_q;
   logic             end_q;
   logic [1:0]       tipo_q;
   logic [LEN_W-1:0] len_q;
   logic             ovf_q;

   logic       accept;
   logic       isTerm;
   logic [3:0] note;
   logic [6:0] glyph;
   logic       wordFull;

   assign noteBus.in_ready = (state_q != EMIT);
   assign accept   = noteBus.in_valid && noteBus.in_ready;
   assign isTerm   = (noteBus.Nota == NOTE_TERM);
   assign note     = {noteBus.Tom, noteBus.Nota};
   assign wordFull = (count_q == LEN_W'(MAX_LEN));

   note_seg_decoder u_segDecoder (
      .nota_i (noteBus.Nota),
      .seg_o  (glyph)
   );

   // Word FSM; results are latched on entry to EMIT and held until the next one
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         count_q <= '0;
         key_q   <= '0;
         saida_q <= SEG_DASH;
         end_q   <= 1'b0;
         tipo_q  <= TIPO_NONE;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         end_q <= 1'b0;
         if (accept) saida_q <= glyph;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (isTerm) begin
                     state_q <= EMIT;
                     end_q   <= 1'b1;
                     tipo_q  <= TIPO_NONE;
                     len_q   <= '0;
                     ovf_q   <= 1'b0;
                  end else begin
                     state_q <= COLLECT;
                     count_q <= LEN_W'(1);
                     key_q   <= note;
                  end
               end
            end
            COLLECT: begin
               if (accept) begin
                  if (isTerm) begin
                     state_q <= EMIT;
                     end_q   <= 1'b1;
                     tipo_q  <= tipoOf(key_q);
                     len_q   <= count_q;
                     ovf_q   <= 1'b0;
                  end else if (wordFull) begin
                     state_q <= DRAIN;
                  end else begin
                     count_q <= count_q + LEN_W'(1);
                     if (!CLASS_BY_FIRST) key_q <= note;
                  end
               end
            end
            DRAIN: begin
               if (accept && isTerm) begin
                  state_q <= EMIT;
                  end_q   <= 1'b1;
                  tipo_q  <= TIPO_NONE;
                  len_q   <= LEN_W'(MAX_LEN);
                  ovf_q   <= 1'b1;
               end
            end
            EMIT: begin
               state_q <= IDLE;
               count_q <= '0;
               key_q   <= '0;
            end
         endcase
      end
   end

   assign Saida    = saida_q;
   assign End      = end_q;
   assign Tipo     = tipo_q;
   assign Len      = len_q;
   assign Overflow = ovf_q;

`ifdef WORD_HIST_EN
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [3:0] hist_q [MAX_LEN];
   logic       countedNote;

   // Only counted notes land in the buffer, so it stays frozen after EMIT
   assign countedNote = accept && !isTerm &&
                        ((state_q == IDLE) || (state_q == COLLECT && !wordFull));

   always_ff @(posedge clk) begin
      if (countedNote) hist_q[count_q[IDX_W-1:0]] <= note;
   end

   assign hist_note = (hist_idx < len_q) ? hist_q[hist_idx[IDX_W-1:0]] : 4'b0000;
`endif

endmodule

// File: tb/tb_note_word_classifier.sv
// Directed scoreboard bench: two classifiers (classify by last / by first note)
// driven with the same note stream, results compared at each End pulse.
module tb_note_word_classifier;
   import note_pkg::*;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   typedef struct packed {
      logic [1:0]       tipo;
      logic [LEN_W-1:0] len;
      logic             ovf;
   } result_t;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   note_word_classifier_if bus0 ();
   note_word_classifier_if bus1 ();

   logic [6:0]       saida0, saida1;
   logic             end0, end1;
   logic [1:0]       tipo0, tipo1;
   logic [LEN_W-1:0] len0, len1;
   logic             ovf0, ovf1;
`ifdef WORD_HIST_EN
   logic [LEN_W-1:0] histIdx;
   logic [3:0]       histNote0, histNote1;
`endif

   note_word_classifier #(.MAX_LEN(MAX_LEN), .CLASS_BY_FIRST(1'b0)) dut0 (
      .clk(clk), .Reset(Reset), .noteBus(bus0),
      .Saida(saida0), .End(end0), .Tipo(tipo0), .Len(len0), .Overflow(ovf0)
`ifdef WORD_HIST_EN
      , .hist_idx(histIdx), .hist_note(histNote0)
`endif
   );

   note_word_classifier #(.MAX_LEN(MAX_LEN), .CLASS_BY_FIRST(1'b1)) dut1 (
      .clk(clk), .Reset(Reset), .noteBus(bus1),
      .Saida(saida1), .End(end1), .Tipo(tipo1), .Len(len1), .Overflow(ovf1)
`ifdef WORD_HIST_EN
      , .hist_idx(histIdx), .hist_note(histNote1)
`endif
   );

   result_t    expQ0[$];
   result_t    expQ1[$];
   logic [3:0] wordNotes[$];
   logic [1:0] lastTipo0;
   int         checkCount = 0;
   int         failCount  = 0;
   logic       prevEnd0, prevEnd1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [6:0] expGlyph(input logic [2:0] n);
      case (n)
         3'd1:    expGlyph = 7'h08;
         3'd2:    expGlyph = 7'h03;
         3'd3:    expGlyph = 7'h46;
         3'd4:    expGlyph = 7'h21;
         3'd5:    expGlyph = 7'h06;
         3'd6:    expGlyph = 7'h0E;
         3'd7:    expGlyph = 7'h42;
         default: expGlyph = 7'h3F;
      endcase
   endfunction

   function automatic logic [1:0] expTipo(input logic [3:0] k);
      case (k)
         4'b0011: expTipo = 2'b11;
         4'b0100: expTipo = 2'b10;
         4'b0101: expTipo = 2'b01;
         default: expTipo = 2'b00;
      endcase
   endfunction

   // Reference result of the word collected so far, for both classify modes
   task automatic pushExpected();
      result_t r0, r1;
      int n;
      int cnt;
      logic ovf;
      n   = wordNotes.size();
      ovf = (n > MAX_LEN);
      cnt = ovf ? MAX_LEN : n;
      r0.len = LEN_W'(cnt);
      r0.ovf = ovf;
      r1     = r0;
      r0.tipo = (n == 0 || ovf) ? 2'b00 : expTipo(wordNotes[cnt-1]);
      r1.tipo = (n == 0 || ovf) ? 2'b00 : expTipo(wordNotes[0]);
      expQ0.push_back(r0);
      expQ1.push_back(r1);
      lastTipo0 = r0.tipo;
      wordNotes.delete();
   endtask

   task automatic applyStimulus(input logic tom, input logic [2:0] nota);
      int waitCycles = 0;
      @(negedge clk);
      while (!(bus0.in_ready && bus1.in_ready) && waitCycles < 4) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("readyBeforeDrive", bus0.in_ready, 1'b1);
      bus0.in_valid = 1'b1; bus0.Tom = tom; bus0.Nota = nota;
      bus1.in_valid = 1'b1; bus1.Tom = tom; bus1.Nota = nota;
      if (nota == 3'b000) pushExpected();
      else wordNotes.push_back({tom, nota});
      @(posedge clk);
      #1;
      bus0.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
      checkOutput("saida0", saida0, expGlyph(nota));
      checkOutput("saida1", saida1, expGlyph(nota));
      checkOutput("endLatency0", end0, (nota == 3'b000));
   endtask

   // Scoreboard: pop one expected result per End pulse of each DUT
   always @(negedge clk) begin
      result_t e0, e1;
      if (!Reset) begin
         if (end0) begin
            e0 = '1;
            if (expQ0.size() > 0) e0 = expQ0.pop_front();
            checkOutput("tipo0", tipo0, e0.tipo);
            checkOutput("len0", len0, e0.len);
            checkOutput("ovf0", ovf0, e0.ovf);
            checkOutput("readyInEmit0", bus0.in_ready, 1'b0);
         end
         if (end1) begin
            e1 = '1;
            if (expQ1.size() > 0) e1 = expQ1.pop_front();
            checkOutput("tipo1", tipo1, e1.tipo);
            checkOutput("len1", len1, e1.len);
            checkOutput("ovf1", ovf1, e1.ovf);
         end
         if (prevEnd0) checkOutput("endWidth0", end0, 1'b0);
         if (prevEnd1) checkOutput("endWidth1", end1, 1'b0);
      end
      prevEnd0 <= end0;
      prevEnd1 <= end1;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      Reset = 1'b1;
      bus0.in_valid = 1'b0; bus0.Tom = 1'b0; bus0.Nota = 3'b000;
      bus1.in_valid = 1'b0; bus1.Tom = 1'b0; bus1.Nota = 3'b000;
`ifdef WORD_HIST_EN
      histIdx = '0;
`endif
      #2;
      checkOutput("resetSaida", saida0, 7'h3F);
      checkOutput("resetEnd", end0, 1'b0);
      checkOutput("resetTipo", tipo0, 2'b00);
      checkOutput("resetLen", len0, 0);
      checkOutput("resetOvf", ovf0, 1'b0);
      checkOutput("resetReady", bus0.in_ready, 1'b1);
      @(negedge clk);
      Reset = 1'b0;

      $display("[TB] word C,D,E");
      applyStimulus(1'b0, NOTE_C);
      applyStimulus(1'b0, NOTE_D);
      applyStimulus(1'b0, NOTE_E);
      applyStimulus(1'b0, NOTE_TERM);

      $display("[TB] empty word back-to-back");
      applyStimulus(1'b0, NOTE_TERM);
      @(negedge clk);
      checkOutput("readyEmitCycle", bus0.in_ready, 1'b0);
      @(negedge clk);
      checkOutput("readyAfterEmit", bus0.in_ready, 1'b1);

      $display("[TB] sharp vs natural D");
      applyStimulus(1'b1, NOTE_D);
      applyStimulus(1'b0, NOTE_TERM);
      applyStimulus(1'b0, NOTE_D);
      applyStimulus(1'b0, NOTE_TERM);

      $display("[TB] overflow word");
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, NOTE_C);
      applyStimulus(1'b0, NOTE_E);
      applyStimulus(1'b0, NOTE_TERM);

      $display("[TB] first/last classify and mid-word reset");
      applyStimulus(1'b0, NOTE_C);
      applyStimulus(1'b0, NOTE_E);
      applyStimulus(1'b0, NOTE_TERM);
      applyStimulus(1'b0, NOTE_D);
      @(posedge clk);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("midResetSaida", saida0, 7'h3F);
      checkOutput("midResetTipo0", tipo0, 2'b00);
      checkOutput("midResetTipo1", tipo1, 2'b00);
      checkOutput("midResetLen", len0, 0);
      checkOutput("midResetSaida1", saida1, 7'h3F);
      #1;
      Reset = 1'b0;
      wordNotes.delete();
      applyStimulus(1'b0, NOTE_D);
      applyStimulus(1'b0, NOTE_TERM);

`ifdef WORD_HIST_EN
      $display("[TB] word history");
      applyStimulus(1'b0, NOTE_A);
      applyStimulus(1'b1, NOTE_G);
      applyStimulus(1'b0, NOTE_C);
      applyStimulus(1'b0, NOTE_TERM);
      repeat (2) @(negedge clk);
      histIdx = LEN_W'(0); #1; checkOutput("hist0", histNote0, 4'h1);
      histIdx = LEN_W'(1); #1; checkOutput("hist1", histNote0, 4'hF);
      histIdx = LEN_W'(2); #1; checkOutput("hist2", histNote0, 4'h3);
      histIdx = LEN_W'(3); #1; checkOutput("hist3", histNote0, 4'h0);
      histIdx = LEN_W'(7); #1; checkOutput("hist7", histNote1, 4'h0);
`endif

      repeat (3) @(negedge clk);
      checkOutput("tipoHold", tipo0, lastTipo0);
      checkOutput("scoreboardDrained", expQ0.size() + expQ1.size(), 0);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
